// File: rtl/axi_fifo_bram_pkt.sv
`default_nettype none
// ============================================================================
// Module   : axi_fifo_bram_pkt
// Purpose  : Block-RAM AXI-Stream FIFO with tlast, optional packet mode,
//            exact fill accounting and almost-full/almost-empty flags.
// Revision : 1.0  initial release
// ============================================================================
module axi_fifo_bram_pkt #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 9,
  parameter int PKT_MODE  = 0,
  parameter int AF_THRESH = (1 << SIZE) - 8,
  parameter int AE_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic [15:0]      pkt_count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int            c_CAP     = 1 << SIZE;
  localparam logic [15:0]   c_CAP16   = 16'(c_CAP);
  localparam logic [15:0]   c_AF      = 16'(AF_THRESH);
  localparam logic [15:0]   c_AE      = 16'(AE_THRESH);
  localparam logic [15:0]   c_ONE16   = 16'd1;
  localparam logic [SIZE:0] c_ONE_CNT = {{SIZE{1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] c_ONE_PTR = {{(SIZE-1){1'b0}}, 1'b1};

  logic [WIDTH:0]    r_mem [c_CAP];
  logic [SIZE-1:0]   r_wr_ptr;
  logic [SIZE-1:0]   r_rd_ptr;
  // Committed-but-unread RAM words are counted rather than derived from
  // pointer compares, so a RAM holding all CAP words stays unambiguous.
  logic [SIZE:0]     r_uncommitted;
  logic [SIZE:0]     r_commit_add;
  logic [SIZE:0]     r_avail;
  logic [15:0]       r_occupied;
  logic [15:0]       r_pkt_count;

  logic [SIZE:0]     w_uncommitted_nxt;
  logic [SIZE:0]     w_commit_add_nxt;
  logic [SIZE:0]     w_avail_nxt;
  logic [15:0]       w_occupied_nxt;
  logic [15:0]       w_pkt_count_nxt;
  logic              w_flush;
  logic              w_wr;
  logic              w_rd;
  logic              w_ram_rd;
  logic              w_guard;

  assign w_flush   = reset | clear;
  assign i_tready  = (r_occupied < c_CAP16);
  assign w_wr      = i_tvalid & i_tready;
  assign w_rd      = o_tvalid & o_tready;
  assign w_ram_rd  = (r_avail != '0) & (~o_tvalid | o_tready);
  // Full with nothing readable: release the partial packet so it can drain.
  assign w_guard   = (PKT_MODE != 0) && (r_occupied == c_CAP16) &&
                     (r_avail == '0) && (r_commit_add == '0);

  assign occupied  = r_occupied;
  assign space     = c_CAP16 - r_occupied;
  assign pkt_count = r_pkt_count;

  always_comb begin
    w_uncommitted_nxt = r_uncommitted;
    w_commit_add_nxt  = '0;
    if (w_wr) begin
      if (PKT_MODE == 0) begin
        w_commit_add_nxt = c_ONE_CNT;
      end else if (i_tlast) begin
        w_commit_add_nxt  = r_uncommitted + c_ONE_CNT;
        w_uncommitted_nxt = '0;
      end else begin
        w_uncommitted_nxt = r_uncommitted + c_ONE_CNT;
      end
    end else if (w_guard) begin
      w_commit_add_nxt  = r_uncommitted;
      w_uncommitted_nxt = '0;
    end
    w_avail_nxt = r_avail + r_commit_add - {{SIZE{1'b0}}, w_ram_rd};

    w_occupied_nxt = r_occupied;
    if (w_wr && !w_rd)
      w_occupied_nxt = r_occupied + c_ONE16;
    else if (!w_wr && w_rd)
      w_occupied_nxt = r_occupied - c_ONE16;

    w_pkt_count_nxt = r_pkt_count;
    if ((w_wr && i_tlast) && !(w_rd && o_tlast))
      w_pkt_count_nxt = r_pkt_count + c_ONE16;
    else if (!(w_wr && i_tlast) && (w_rd && o_tlast))
      w_pkt_count_nxt = r_pkt_count - c_ONE16;
  end

  always_ff @(posedge clk) begin
    if (w_wr && !w_flush)
      r_mem[r_wr_ptr] <= {i_tlast, i_tdata};
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_uncommitted <= '0;
      r_commit_add  <= '0;
      r_avail       <= '0;
      r_occupied    <= '0;
      r_pkt_count   <= '0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      o_tvalid      <= 1'b0;
      o_tdata       <= '0;
      o_tlast       <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
      if (w_ram_rd)
        r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
      r_uncommitted <= w_uncommitted_nxt;
      r_commit_add  <= w_commit_add_nxt;
      r_avail       <= w_avail_nxt;
      r_occupied    <= w_occupied_nxt;
      r_pkt_count   <= w_pkt_count_nxt;
      almost_full   <= (w_occupied_nxt >= c_AF);
      almost_empty  <= (w_occupied_nxt <= c_AE);
      if (w_ram_rd) begin
        {o_tlast, o_tdata} <= r_mem[r_rd_ptr];
        o_tvalid           <= 1'b1;
      end else if (w_rd) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_fifo_bram_pkt.md
Name: axi_fifo_bram_pkt

Overview:
Block-RAM AXI-Stream FIFO with tlast support, an optional packet mode, exact fill accounting, and programmable almost-full/almost-empty flags. It is the parametrised successor to the team's plain BRAM FIFO. It sits between packet producers (framers, DMA) and consumers that must never see a partial packet. Storage is one simple dual-port RAM plus a one-word registered output stage.

Parameters:
WIDTH, 32, data width in bits
SIZE, 9, log2 of RAM depth; total capacity CAP = 2^SIZE words, output register included
PKT_MODE, 0, 0 = streaming; 1 = a word is readable only after its packet's tlast word has been written
AF_THRESH, 2^SIZE-8, almost_full asserts when occupied >= AF_THRESH
AE_THRESH, 8, almost_empty asserts when occupied <= AE_THRESH

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
clear  in  1  synchronous flush, same effect as reset
i_tdata  in  WIDTH  input data
i_tlast  in  1  input end of packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  WIDTH  output data, registered
o_tlast  out  1  output end of packet, registered
o_tvalid  out  1  output valid, registered
o_tready  in  1  output ready
space  out  16  exact free words (CAP - occupied)
occupied  out  16  exact words held, output register included
pkt_count  out  16  complete packets held (tlast words written, not yet read)
almost_full  out  1  registered threshold flag
almost_empty  out  1  registered threshold flag

Behaviour:
- Reset/clear: pointers 0; o_tvalid=0, o_tdata=0, o_tlast=0; occupied=0, space=CAP, pkt_count=0; almost_full=0, almost_empty=1; i_tready=1 on the first cycle after reset deasserts.
- Clear has priority: a write or read in the clear cycle is discarded and the counters do not move.
- Write = i_tvalid & i_tready. Read = o_tvalid & o_tready.
- i_tready = (occupied < CAP), derived combinationally from registered state. Never asserts with occupied == CAP.
- RAM stores {tlast, data}. wr_ptr and rd_ptr are SIZE bits and wrap modulo 2^SIZE. Fullness comes from the occupancy counters, never from pointer equality.
- commit_ptr marks the readable limit.
  - PKT_MODE=0: commit_ptr tracks wr_ptr.
  - PKT_MODE=1: commit_ptr <= wr_ptr+1 on a write with i_tlast=1.
- Prefetch: a RAM read issues when rd_ptr != commit_ptr and the output stage is empty or being read in the same cycle. RAM read latency is 1 cycle, and the data lands in the output register.
- Latency from a write at edge N into an empty FIFO to o_tvalid=1 is 2 edges (N+2).
  - PKT_MODE=1: measured from the tlast write.
  - Sustained throughput is 1 word/cycle with no bubbles while o_tready=1.
- Output hold: o_tdata, o_tlast and o_tvalid stay stable while o_tvalid & ~o_tready.
- occupied: +1 on write only, -1 on read only, unchanged on both or neither. space is updated in lockstep.
- pkt_count: +1 on a write with i_tlast, -1 on a read with o_tlast; a simultaneous increment and decrement nets 0. It counts in both modes.
- almost_full and almost_empty are registered from the next-cycle value of occupied, so they are in sync with occupied.
- Oversize guard (PKT_MODE=1): if occupied==CAP and rd_ptr==commit_ptr, set commit_ptr <= wr_ptr. The partial packet drains, so the FIFO cannot deadlock. Later words of that packet follow normal commit rules.
- Reset or clear mid-packet discards all partial and complete packets; the next accepted word is the first word of a new packet.
- Empty: o_tvalid falls on the edge after the last word is read if nothing committed remains. It is never asserted with stale data.

Test Plan:
1. SIZE=4, PKT_MODE=0, o_tready=0, write 0..20 continuously -> words 0..15 accepted; i_tready=0 after the 16th; occupied=16, space=0, almost_full=1. Then o_tready=1 -> 0..15 out on consecutive cycles; occupied returns to 0.
2. Single write of 0xA5 at edge N into an empty FIFO -> o_tvalid=1 with o_tdata=0xA5 at edge N+2; almost_empty stays 1.
3. PKT_MODE=1: write words 1 and 2 without tlast, idle 10 cycles -> o_tvalid stays 0, pkt_count=0. Write 3 with tlast -> pkt_count=1, o_tvalid 2 edges later, outputs 1,2,3 with o_tlast only on 3, then pkt_count=0.
4. PKT_MODE=1, SIZE=4: write 16 words with no tlast -> full, oversize guard releases, all 16 drain in order. Writing the 17th word with tlast afterwards delivers it with o_tlast=1.
5. Random i_tvalid/o_tready at 50% for 10,000 cycles, so pointers wrap many times, with random tlast -> output sequence equals input sequence; occupied, space and pkt_count match the scoreboard every cycle.
6. Assert clear on the same cycle as a write while holding 5 words -> occupied=0, o_tvalid=0 next cycle, the clear-cycle word is discarded, and the next written word is the next one output.
